// File: rtl/bmult_pkg.sv
// rtl/bmult_pkg.sv - shared sizing helpers for the pipelined multiplier
//
// Purpose: width helpers used by bmult_pipe and bmult_pp_stage.
//   slice_width(wb, stages) : ceil(wb/stages), bits of B consumed per stage.
//   prod_width(wa, wb)      : full product width, also the accumulator width.
// Ports: none (package).
package bmult_pkg;

  function automatic int slice_width(input int wb, input int stages);
    return (wb + stages - 1) / stages;
  endfunction

  function automatic int prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/bmult_pp_stage.sv
// rtl/bmult_pp_stage.sv - one partial-product accumulate stage of bmult_pipe
//
// Purpose: registers acc + (a * b_slice) << (IDX*SW), where b_slice is the low
// SW bits of the remaining B. It forwards a, the remaining B shifted down by one
// slice, and the tag.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   en                   advance enable (low while the pipe is stalled)
//   in_valid/out_valid   stage valid bit
//   in_acc/out_acc       running partial sum, PW bits
//   in_a/out_a           operand A, carried along with the data
//   in_b/out_b           remaining B slices, current slice in the LSBs
//   in_tag/out_tag       transaction tag
module bmult_pp_stage
  import bmult_pkg::*;
#(
  parameter int WA     = 22,
  parameter int WB     = 22,
  parameter int STAGES = 2,
  parameter int TAGW   = 4,
  parameter int IDX    = 0,
  localparam int SW    = slice_width(WB, STAGES),
  localparam int BW    = SW * STAGES,
  localparam int PW    = prod_width(WA, WB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic [PW-1:0]   in_acc,
  input  logic [WA-1:0]   in_a,
  input  logic [BW-1:0]   in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  output logic [PW-1:0]   out_acc,
  output logic [WA-1:0]   out_a,
  output logic [BW-1:0]   out_b,
  output logic [TAGW-1:0] out_tag
);

  logic [SW-1:0] slice;
  logic [PW-1:0] partial;

  assign slice   = in_b[SW-1:0];
  // The full product fits in PW bits, so truncating the shifted term is exact.
  assign partial = (PW'(in_a) * PW'(slice)) << (IDX * SW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      // Data only moves with a valid word, so the final stage keeps showing
      // the last real product across bubbles.
      if (in_valid) begin
        out_acc <= in_acc + partial;
        out_a   <= in_a;
        out_b   <= in_b >> SW;
        out_tag <= in_tag;
      end
    end
  end

endmodule

// File: rtl/bmult_pipe.sv
// rtl/bmult_pipe.sv - STAGES-deep pipelined unsigned multiplier with handshake
//
// Purpose: out_p = in_a * in_b, computed over STAGES stages of B-slice
// partial-product accumulation, with valid/ready handshaking, a global stall
// and tag passthrough.
// Optional: define BMULT_PIPE_PERF_CNT_EN to add perf_cnt (output transfers,
// wrapping) and stall_cnt (stall cycles, saturating).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          input handshake
//   in_a, in_b, in_tag         operands and tag
//   out_valid/out_ready        output handshake
//   out_p, out_tag             product and its tag
//   perf_cnt, stall_cnt        counters, present only with BMULT_PIPE_PERF_CNT_EN
module bmult_pipe
  import bmult_pkg::*;
#(
  parameter int WA     = 22,
  parameter int WB     = 22,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WA-1:0]      in_a,
  input  logic [WB-1:0]      in_b,
  input  logic [TAGW-1:0]    in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WA+WB-1:0]   out_p,
  output logic [TAGW-1:0]    out_tag
`ifdef BMULT_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int SW = slice_width(WB, STAGES);
  localparam int BW = SW * STAGES;
  localparam int PW = prod_width(WA, WB);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic            valid_c [STAGES+1];
  logic [PW-1:0]   acc_c   [STAGES+1];
  logic [WA-1:0]   a_c     [STAGES+1];
  logic [BW-1:0]   b_c     [STAGES+1];
  logic [TAGW-1:0] tag_c   [STAGES+1];

  logic ready_q;
  logic stall;
  logic accept;
  logic unused_tail;

  // Held low in reset and for the first cycle after, then tracks !stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign stall    = out_valid && !out_ready;
  assign in_ready = ready_q && !stall;
  assign accept   = in_valid && in_ready;

  assign valid_c[0] = accept;
  assign acc_c[0]   = '0;
  assign a_c[0]     = in_a;
  assign b_c[0]     = BW'(in_b);
  assign tag_c[0]   = in_tag;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    bmult_pp_stage #(
      .WA(WA), .WB(WB), .STAGES(STAGES), .TAGW(TAGW), .IDX(k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (!stall),
      .in_valid (valid_c[k]),
      .in_acc   (acc_c[k]),
      .in_a     (a_c[k]),
      .in_b     (b_c[k]),
      .in_tag   (tag_c[k]),
      .out_valid(valid_c[k+1]),
      .out_acc  (acc_c[k+1]),
      .out_a    (a_c[k+1]),
      .out_b    (b_c[k+1]),
      .out_tag  (tag_c[k+1])
    );
  end

  assign out_valid = valid_c[STAGES];
  assign out_p     = acc_c[STAGES];
  assign out_tag   = tag_c[STAGES];

  // A and the exhausted B slices leaving the last stage have no consumer.
  assign unused_tail = &{1'b0, a_c[STAGES], b_c[STAGES]};

`ifdef BMULT_PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready)
        perf_cnt <= perf_cnt + 32'd1;
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bmult_pipe.sv
// tb/tb_bmult_pipe.sv - self-checking bench for bmult_pipe
module tb_bmult_pipe;
  parameter int STAGES = 2;
  localparam int WA   = 22;
  localparam int WB   = 22;
  localparam int TAGW = 4;
  localparam int PW   = WA + WB;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WA-1:0]   in_a;
  logic [WB-1:0]   in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_p;
  logic [TAGW-1:0] out_tag;
`ifdef BMULT_PIPE_PERF_CNT_EN
  logic [31:0]     perf_cnt;
  logic [31:0]     stall_cnt;
`endif

  bmult_pipe #(.WA(WA), .WB(WB), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_tag  (out_tag)
`ifdef BMULT_PIPE_PERF_CNT_EN
    ,
    .perf_cnt (perf_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: each accepted pair becomes a queued product that must
  // surface STAGES cycles after acceptance, pushed back one cycle per stall.
  typedef struct {
    logic [PW-1:0]   p;
    logic [TAGW-1:0] t;
    int              c;
    int              s;
  } item_t;

  item_t           q[$];
  logic [PW-1:0]   retired[$];
  logic [PW-1:0]   last_p;
  logic [TAGW-1:0] last_t;
  int              cyc = 0;
  int              stalls = 0;
  int              since_rst = 0;
  int              xfer_since = 0;
  int              stall_since = 0;

  always @(negedge clk) begin
    logic  exp_v;
    logic  exp_stall;
    item_t it;
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_p", 64'(out_p), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      q.delete();
      last_p      = '0;
      last_t      = '0;
      since_rst   = 0;
      xfer_since  = 0;
      stall_since = 0;
    end else begin
      exp_v = 1'b0;
      if (q.size() > 0)
        exp_v = ((cyc - q[0].c) - (stalls - q[0].s)) >= STAGES;
      exp_stall = exp_v && !out_ready;
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
        last_p = q[0].p;
        last_t = q[0].t;
      end
      chk("out_p", 64'(out_p), 64'(last_p));
      chk("out_tag", 64'(out_tag), 64'(last_t));
      chk("in_ready", 64'(in_ready), 64'((since_rst > 0) && !exp_stall));
      if (exp_v && out_ready) begin
        retired.push_back(out_p);
        void'(q.pop_front());
        xfer_since++;
      end
      if (in_valid && in_ready) begin
        it.p = PW'(in_a) * PW'(in_b);
        it.t = in_tag;
        it.c = cyc;
        it.s = stalls;
        q.push_back(it);
      end
      if (exp_stall) begin
        stalls++;
        stall_since++;
      end
      cyc++;
      since_rst++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [TAGW-1:0] t);
    int   n;
    logic ok;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int     n;
    int     seen;
    longint t0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_tag = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Full-scale operands: (2^22-1)^2.
    send(22'h3FFFFF, 22'h3FFFFF, 4'h5);
    in_valid = 1'b0;
    wait_out(n);
    chk("max_latency", 64'(n), 64'(STAGES));
    chk("max_p", 64'(out_p), 64'hFFFFF800001);
    chk("max_tag", 64'(out_tag), 64'h5);
    idle(3);

    // Alternating bit patterns.
    send(22'h2AAAAA, 22'h155555, 4'h7);
    in_valid = 1'b0;
    wait_out(n);
    chk("alt_latency", 64'(n), 64'(STAGES));
    chk("alt_p", 64'(out_p), 64'h38E38C71C72);
    idle(3);

    // Bubble: valid, gap, valid.
    send(22'd6, 22'd7, 4'h1);
    in_valid = 1'b0;
    idle(1);
    send(22'd9, 22'd9, 4'h2);
    in_valid = 1'b0;
    idle(STAGES + 3);
    chk("bubble_p0", 64'(retired[retired.size()-2]), 64'd42);
    chk("bubble_p1", 64'(retired[retired.size()-1]), 64'd81);

    // Backpressure: consumer refuses for 4 cycles once the first product shows.
    out_ready = 1'b0;
    fork
      begin
        send(22'd3, 22'd5, 4'h1);
        send(22'd0, 22'h3FFFFF, 4'h2);
        send(22'd1, 22'd1, 4'h3);
        in_valid = 1'b0;
      end
      begin
        wait_out(n);
        chk("bp_first_p", 64'(out_p), 64'hF);
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_hold_p", 64'(out_p), 64'hF);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(STAGES + 4);
    chk("bp_ret0", 64'(retired[retired.size()-3]), 64'hF);
    chk("bp_ret1", 64'(retired[retired.size()-2]), 64'h0);
    chk("bp_ret2", 64'(retired[retired.size()-1]), 64'h1);

    // Reset with work in flight.
    send(22'd5, 22'd6, 4'h4);
    send(22'd7, 22'd8, 4'h5);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_p", 64'(out_p), 64'd0);
    idle(2);
    rst = 1'b0;
    seen = 0;
    repeat (STAGES + 5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_stale", 64'(seen), 64'd0);
    idle(1);

    // Back-to-back random stream.
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 20000; i++)
      send(WA'($urandom), WB'($urandom), TAGW'($urandom));
    chk("stream_cycles", 64'(($time - t0) / 10), 64'd20000);
    in_valid = 1'b0;
    idle(STAGES + 4);
    chk("drained", 64'(q.size()), 64'd0);

`ifdef BMULT_PIPE_PERF_CNT_EN
    @(negedge clk);
    chk("perf_cnt", 64'(perf_cnt), 64'(xfer_since));
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_since));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
